// File: rtl/sn74xx93_counter.sv
// sn74xx93_counter
//   Clock-synchronous equivalent of the 74xx93 4-bit ripple binary counter.
//   It has two independent sections. The A section divides by 2 (clka -> outa).
//   The B section divides by 2^WIDTH_B (clkb -> outb).
//   Each section advances on a falling edge of its count pin. The pins are
//   sampled on the rising edge of clk.
//   Tie outa to clkb externally to get a divide-by-16 counter with {outb,outa}
//   as the count.
//
//   Optional build macro: SN74XX93_SYNC_EN
//     When it is defined, clka and clkb each pass through a 2-flop
//     synchronizer before edge detection. The pins may then be asynchronous to
//     clk, and the outputs update 2 clk cycles later.
//
// Ports
//   clk   in   1        system clock, rising edge
//   r0    in   1        reset gate 1; r0 & r1 clears the counter asynchronously
//   r1    in   1        reset gate 2
//   clka  in   1        A-section count pin, counts on 1->0
//   clkb  in   1        B-section count pin, counts on 1->0
//   outa  out  1        A-section state (QA)
//   outb  out  WIDTH_B  B-section state (outb[0] = QB, LSB)

module sn74xx93_counter #(
  parameter int unsigned WIDTH_B = 3
) (
  input  logic               clk,
  input  logic               r0,
  input  logic               r1,
  input  logic               clka,
  input  logic               clkb,
  output logic               outa,
  output logic [WIDTH_B-1:0] outb
);

  // Both reset gates must be high, as on the TTL part.
  logic rst;
  assign rst = r0 & r1;

  logic a_smp;
  logic b_smp;

`ifdef SN74XX93_SYNC_EN
  logic [1:0] a_sync_q;
  logic [1:0] b_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q <= 2'b00;
      b_sync_q <= 2'b00;
    end else begin
      a_sync_q <= {a_sync_q[0], clka};
      b_sync_q <= {b_sync_q[0], clkb};
    end
  end

  assign a_smp = a_sync_q[1];
  assign b_smp = b_sync_q[1];
`else
  assign a_smp = clka;
  assign b_smp = clkb;
`endif

  // The history flops are cleared by reset. A pin must therefore be seen high
  // after reset release before its next low sample can count.
  logic a_hist_q;
  logic b_hist_q;
  logic a_fall;
  logic b_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_hist_q <= 1'b0;
      b_hist_q <= 1'b0;
    end else begin
      a_hist_q <= a_smp;
      b_hist_q <= b_smp;
    end
  end

  assign a_fall = a_hist_q & ~a_smp;
  assign b_fall = b_hist_q & ~b_smp;

  logic               outa_q;
  logic               outa_d;
  logic [WIDTH_B-1:0] outb_q;
  logic [WIDTH_B-1:0] outb_d;

  always_comb begin
    outa_d = outa_q;
    outb_d = outb_q;
    if (a_fall) begin
      outa_d = ~outa_q;
    end
    if (b_fall) begin
      outb_d = outb_q + WIDTH_B'(1);  // wraps modulo 2^WIDTH_B
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outa_q <= 1'b0;
      outb_q <= '0;
    end else begin
      outa_q <= outa_d;
      outb_q <= outb_d;
    end
  end

  assign outa = outa_q;
  assign outb = outb_q;

endmodule

// File: tb/tb_sn74xx93_counter.sv
// tb_sn74xx93_counter
//   Self-checking bench for sn74xx93_counter (WIDTH_B = 3).
//   A vector table holds the expected outputs at the unsynchronized latency.
//   Those expectations are delayed through a scoreboard queue by the
//   synchronizer depth. Hand-written sequences cover:
//     - asynchronous reset,
//     - the outa->clkb cascade, with per-edge latency checks.

module tb_sn74xx93_counter;

  localparam int LAT =
`ifdef SN74XX93_SYNC_EN
    2;
`else
    0;
`endif

  logic       clk;
  logic       clk_en;
  logic       r0;
  logic       r1;
  logic       clka;
  logic       clkb_drv;
  logic       casc;
  logic       clkb_pin;
  logic       outa;
  logic [2:0] outb;

  // Cascade mode wires outa back to clkb, as in the divide-by-16 hookup.
  assign clkb_pin = casc ? outa : clkb_drv;

  sn74xx93_counter #(
    .WIDTH_B(3)
  ) dut (
    .clk (clk),
    .r0  (r0),
    .r1  (r1),
    .clka(clka),
    .clkb(clkb_pin),
    .outa(outa),
    .outb(outb)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       r0;
    logic       r1;
    logic       ca;
    logic       cb;
    logic       ea;
    logic [2:0] eb;
  } vec_t;

  typedef struct {
    logic       a;
    logic [2:0] b;
  } exp_t;

  vec_t tv[$];
  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic add(input logic r0v, input logic r1v, input logic ca, input logic cb,
                     input logic ea, input logic [2:0] eb);
    vec_t v;
    v.r0 = r0v; v.r1 = r1v; v.ca = ca; v.cb = cb; v.ea = ea; v.eb = eb;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic ea, input logic [2:0] eb);
    nvec++;
    if (outa !== ea || outb !== eb) begin
      nerr++;
      $display("FAIL %s: got outa=%b outb=%b, want outa=%b outb=%b",
               name, outa, outb, ea, eb);
    end
  endtask

  // Push the expectation, advance one clk edge, then pop and compare.
  task automatic step_chk(input string name, input logic ea, input logic [2:0] eb);
    exp_t e;
    e.a = ea;
    e.b = eb;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk(name, e.a, e.b);
  endtask

  initial begin
    exp_t       e;
    exp_t       z;
    logic [3:0] cnt;
    logic [3:0] nxt;
    logic       ea;
    logic [2:0] eb;

    z.a = 1'b0;
    z.b = 3'd0;
    clk_en = 1'b0;
    casc = 1'b0;
    r0 = 1'b0; r1 = 1'b0; clka = 1'b0; clkb_drv = 1'b0;

    // Reset with the clock stopped: it must take effect with no clk edge.
    #5;
    r0 = 1'b1; r1 = 1'b1;
    #1;
    chk("async_reset_clk_stopped", 1'b0, 3'd0);
    r0 = 1'b0; r1 = 1'b0;
    #3;
    chk("release_holds_zero", 1'b0, 3'd0);

    // Table rows: r0 r1 clka clkb -> outa outb, at zero latency
    add(1,1,0,0, 0,3'd0);  // reset
    add(0,0,0,0, 0,3'd0);  // pin low at release: no count
    add(0,0,0,0, 0,3'd0);
    add(0,0,1,0, 0,3'd0);  // rising edge only
    add(0,0,0,0, 1,3'd0);  // A falls
    add(0,0,0,1, 1,3'd0);
    add(0,0,1,0, 1,3'd1);  // B falls, A rises
    add(0,0,0,0, 0,3'd1);  // A falls
    add(0,0,1,1, 0,3'd1);
    add(0,0,0,0, 1,3'd2);  // simultaneous A and B
    add(0,0,0,0, 1,3'd2);  // held low: no extra counts
    add(0,0,0,0, 1,3'd2);
    add(0,0,0,1, 1,3'd2);
    add(0,0,0,0, 1,3'd3);
    add(0,0,0,1, 1,3'd3);
    add(0,0,0,0, 1,3'd4);
    add(0,0,0,1, 1,3'd4);
    add(0,0,0,0, 1,3'd5);  // outb = 101
    add(1,0,0,0, 1,3'd5);  // single reset gate: no effect
    add(0,1,0,0, 1,3'd5);
    add(1,0,0,1, 1,3'd5);
    add(1,0,0,0, 1,3'd6);  // counting continues with r0 only
    add(0,1,0,1, 1,3'd6);
    add(0,1,0,0, 1,3'd7);
    add(0,0,0,1, 1,3'd7);
    add(0,0,0,0, 1,3'd0);  // 7 -> 0 wrap
    add(0,0,1,1, 1,3'd0);
    add(1,1,1,1, 0,3'd0);  // reset
    add(1,1,0,0, 0,3'd0);  // falls during reset ignored
    add(1,1,1,1, 0,3'd0);
    add(0,0,0,0, 0,3'd0);  // release with pins low
    add(0,0,1,1, 0,3'd0);
    add(0,0,0,0, 1,3'd1);
    add(1,1,1,1, 0,3'd0);
    add(0,0,1,1, 0,3'd0);  // release with pins high
    add(0,0,0,0, 1,3'd1);
    add(0,0,1,1, 1,3'd1);
    add(1,1,1,1, 0,3'd0);
    add(0,0,0,0, 0,3'd0);
    add(0,0,0,0, 0,3'd0);
    add(0,0,0,0, 0,3'd0);

    clk_en = 1'b1;
    #1;
    foreach (tv[i]) begin
      r0 = tv[i].r0; r1 = tv[i].r1; clka = tv[i].ca; clkb_drv = tv[i].cb;
      if (tv[i].r0 && tv[i].r1) begin
        // A reset drops in-flight pin events, so outputs read 0 for LAT rows.
        sbq.delete();
        repeat (LAT + 1) sbq.push_back(z);
      end else begin
        e.a = tv[i].ea;
        e.b = tv[i].eb;
        sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      if (sbq.size() > LAT) begin
        e = sbq.pop_front();
        chk($sformatf("vec%0d", i), e.a, e.b);
      end
    end
    sbq.delete();

    // Asynchronous reset while the clock runs: check before the next rising edge.
    clka = 1'b1; clkb_drv = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1;
    clka = 1'b0; clkb_drv = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("pre_async_count", 1'b1, 3'd1);
    @(negedge clk);
    r0 = 1'b1; r1 = 1'b1;
    #1;
    chk("async_reset_mid_cycle", 1'b0, 3'd0);

    // Cascade: outa drives clkb, 16 clka falls give {outb,outa} = 1..15, 0.
    casc = 1'b1;
    @(posedge clk);
    #1;
    r0 = 1'b0; r1 = 1'b0;
    cnt = 4'd0;
    for (int k = 0; k < 16; k++) begin
      clka = 1'b1;
      for (int h = 0; h < 6; h++) step_chk($sformatf("casc%0d_high", k), cnt[0], cnt[3:1]);
      clka = 1'b0;
      nxt = cnt + 4'd1;
      for (int j = 1; j <= 6; j++) begin
        ea = (j >= LAT + 1) ? nxt[0] : cnt[0];
        // B moves one clk after outa falls, plus its own synchronizer delay.
        eb = (cnt[0] && j >= 2 * LAT + 2) ? nxt[3:1] : cnt[3:1];
        step_chk($sformatf("casc%0d_e%0d", k, j), ea, eb);
      end
      cnt = nxt;
    end
    chk("casc_final_zero", 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
